// File: rtl/axi_pkt_pkg.sv
// ============================================================================
// Module : axi_pkt_pkg
// Brief  : Shared framing constants and depacketizer state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi_pkt_pkg;

    localparam int c_PKT_LEN = 256;
    localparam int c_CNT_W   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        RESYNC = 2'd2
    } depkt_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_if.sv
// ============================================================================
// Module : axi_if
// Brief  : AXI-Stream bundle with slave and master modports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 8
) ();
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;

    modport slave  (input  tvalid, tdata, tuser, tlast, output tready);
    modport master (output tvalid, tdata, tuser, tlast, input  tready);
endinterface

`default_nettype wire

// File: rtl/axi_skid_buf.sv
// ============================================================================
// Module : axi_skid_buf
// Brief  : Two-entry register slice; input ready is registered so it never
//          depends combinationally on the downstream ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_skid_buf #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_in_ready,
    output logic             o_out_valid,
    output logic [WIDTH-1:0] o_out_data,
    input  logic             i_out_ready
);

    logic             r_ready;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_in_fire;
    logic             w_out_free;
    logic             w_skid_next;

    assign w_in_fire   = i_in_valid && r_ready;
    assign w_out_free  = !r_out_valid || i_out_ready;
    // The skid entry only holds a beat while the output register is blocked.
    assign w_skid_next = !w_out_free && (r_skid_valid || w_in_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_ready      <= !w_skid_next;
            r_skid_valid <= w_skid_next;
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                end else if (w_in_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_in_data;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_data <= i_in_data;
            end
        end
    end

    assign o_in_ready  = r_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/axi_depacketizer.sv
// ============================================================================
// Module : axi_depacketizer
// Brief  : Checks fixed-length AXI-Stream framing, strips tlast and re-emits a
//          continuous beat stream. Optional tuser check: DEPKT_TUSER_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_depacketizer
    import axi_pkt_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int USER_W  = 8,
    parameter int PKT_LEN = c_PKT_LEN,
    parameter int CNT_W   = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    axi_if.slave             s_axi_if,
    axi_if.master            m_axi_if,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_short,
    output logic             err_long,
`ifdef DEPKT_TUSER_CHECK_EN
    output logic             err_user,
`endif
    output logic             resyncing
);

    localparam int                  c_BEAT_W   = $clog2(PKT_LEN);
    localparam logic [c_BEAT_W-1:0] c_LAST_IDX = c_BEAT_W'(PKT_LEN - 1);

    depkt_state_e               r_state;
    logic [c_BEAT_W-1:0]        r_beat_cnt;
    logic [CNT_W-1:0]           r_pkt_count;
    logic [CNT_W-1:0]           r_err_count;
    logic                       r_err_short;
    logic                       r_err_long;
    logic                       r_resyncing;
    logic                       w_skid_ready;
    logic                       w_s_ready;
    logic                       w_acc;
    logic                       w_fwd_valid;
    logic                       w_at_last;
    logic                       w_good;
    logic                       w_short;
    logic                       w_long;
    logic                       w_user;
    logic [1:0]                 w_err_inc;
    logic [CNT_W:0]             w_err_sum;
    logic [CNT_W-1:0]           w_err_next;
    logic [CNT_W-1:0]           w_pkt_next;
    logic                       w_m_valid;
    logic [DATA_W+USER_W-1:0]   w_m_data;

    // RESYNC drains the input regardless of downstream back-pressure.
    assign w_s_ready   = (r_state == RESYNC) || w_skid_ready;
    assign w_acc       = s_axi_if.tvalid && w_s_ready;
    assign w_fwd_valid = s_axi_if.tvalid && (r_state != RESYNC);
    assign w_at_last   = (r_beat_cnt == c_LAST_IDX);

    always_comb begin
        w_good  = 1'b0;
        w_short = 1'b0;
        w_long  = 1'b0;
        if (w_acc) begin
            case (r_state)
                IDLE:    w_short = s_axi_if.tlast;
                IN_PKT: begin
                    w_good  = s_axi_if.tlast && w_at_last;
                    w_short = s_axi_if.tlast && !w_at_last;
                    w_long  = !s_axi_if.tlast && w_at_last;
                end
                default: w_good = 1'b0;
            endcase
        end
    end

`ifdef DEPKT_TUSER_CHECK_EN
    logic [USER_W-1:0] r_user0;
    logic              r_err_user;

    assign w_user   = w_acc && (r_state == IN_PKT) && (s_axi_if.tuser != r_user0);
    assign err_user = r_err_user;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_user0    <= '0;
            r_err_user <= 1'b0;
        end else begin
            r_err_user <= w_user;
            if (w_acc && (r_state == IDLE)) begin
                r_user0 <= s_axi_if.tuser;
            end
        end
    end
`else
    assign w_user = 1'b0;
`endif

    // A framing and a tuser error on one beat both count; carry-out saturates.
    assign w_err_inc  = {1'b0, w_short | w_long} + {1'b0, w_user};
    assign w_err_sum  = {1'b0, r_err_count} + {{(CNT_W-1){1'b0}}, w_err_inc};
    assign w_err_next = w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
    assign w_pkt_next = (w_good && (r_pkt_count != '1)) ? r_pkt_count + CNT_W'(1) : r_pkt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat_cnt  <= '0;
            r_pkt_count <= '0;
            r_err_count <= '0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_resyncing <= 1'b0;
        end else begin
            r_err_short <= w_short;
            r_err_long  <= w_long;
            r_pkt_count <= w_pkt_next;
            r_err_count <= w_err_next;
            if (w_acc) begin
                case (r_state)
                    IDLE: begin
                        if (s_axi_if.tlast) begin
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= c_BEAT_W'(1);
                            r_state    <= IN_PKT;
                        end
                    end
                    IN_PKT: begin
                        if (s_axi_if.tlast) begin
                            r_state    <= IDLE;
                            r_beat_cnt <= '0;
                        end else if (w_at_last) begin
                            r_state     <= RESYNC;
                            r_resyncing <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_BEAT_W'(1);
                        end
                    end
                    RESYNC: begin
                        if (s_axi_if.tlast) begin
                            r_state     <= IDLE;
                            r_beat_cnt  <= '0;
                            r_resyncing <= 1'b0;
                        end
                    end
                    default: begin
                        r_state     <= IDLE;
                        r_beat_cnt  <= '0;
                        r_resyncing <= 1'b0;
                    end
                endcase
            end
        end
    end

    axi_skid_buf #(
        .WIDTH (DATA_W + USER_W)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (w_fwd_valid),
        .i_in_data   ({s_axi_if.tdata, s_axi_if.tuser}),
        .o_in_ready  (w_skid_ready),
        .o_out_valid (w_m_valid),
        .o_out_data  (w_m_data),
        .i_out_ready (m_axi_if.tready)
    );

    assign s_axi_if.tready = w_s_ready;
    assign m_axi_if.tvalid = w_m_valid;
    assign m_axi_if.tdata  = w_m_data[DATA_W+USER_W-1:USER_W];
    assign m_axi_if.tuser  = w_m_data[USER_W-1:0];
    assign m_axi_if.tlast  = 1'b0;

    assign pkt_count = r_pkt_count;
    assign err_count = r_err_count;
    assign err_short = r_err_short;
    assign err_long  = r_err_long;
    assign resyncing = r_resyncing;

endmodule

`default_nettype wire

// File: tb/tb_axi_depacketizer.sv
// ============================================================================
// Module : tb_axi_depacketizer
// Brief  : Self-checking bench; expected behaviour derived per tlast-delimited
//          segment from the framing rules.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_axi_depacketizer;

    localparam int DATA_W  = 32;
    localparam int USER_W  = 8;
    localparam int PKT_LEN = 256;
    localparam int CNT_W   = 32;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [USER_W-1:0] u;
        logic              l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.DATA_W(DATA_W), .USER_W(USER_W)) s_if ();
    axi_if #(.DATA_W(DATA_W), .USER_W(USER_W)) m_if ();

    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;
    logic             err_short;
    logic             err_long;
    logic             resyncing;
`ifdef DEPKT_TUSER_CHECK_EN
    logic             err_user;
`endif

    axi_depacketizer #(
        .DATA_W (DATA_W),
        .USER_W (USER_W),
        .PKT_LEN(PKT_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_axi_if (s_if),
        .m_axi_if (m_if),
        .pkt_count(pkt_count),
        .err_count(err_count),
        .err_short(err_short),
        .err_long (err_long),
`ifdef DEPKT_TUSER_CHECK_EN
        .err_user (err_user),
`endif
        .resyncing(resyncing)
    );

    int checks = 0;
    int errors = 0;

    beat_t in_q[$];
    bit    f_fwd[$], f_good[$], f_short[$], f_long[$], f_user[$], f_rs[$];
    int    n_fwd_exp;
    logic [DATA_W+USER_W-1:0] exp_out[$];
    logic [DATA_W-1:0]        out_log[$];
    longint exp_pkt, exp_err;
    int n_short, n_long, n_user, rs_cycles, run_cycles, src_stalls;
    logic [DATA_W-1:0] next_data;

    task automatic add_seg(input int len, input logic [USER_W-1:0] u, input bit term);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = next_data;
            b.u = u;
            b.l = term && (i == len - 1);
            in_q.push_back(b);
            next_data = next_data + 1;
        end
    endtask

    // Per segment of length L: first min(L,PKT_LEN) beats forwarded; L==PKT_LEN
    // good, L<PKT_LEN short at its end, L>PKT_LEN long at beat PKT_LEN-1 and
    // the remainder (through its tlast) discarded while resyncing.
    task automatic build_model();
        int i, L;
        bit term, last;
        logic [USER_W-1:0] u0;
        f_fwd.delete(); f_good.delete(); f_short.delete();
        f_long.delete(); f_user.delete(); f_rs.delete();
        n_fwd_exp = 0;
        i = 0;
        while (i < in_q.size()) begin
            L = 1;
            while (!in_q[i+L-1].l && (i + L < in_q.size())) L++;
            term = in_q[i+L-1].l;
            u0   = in_q[i].u;
            for (int p = 0; p < L; p++) begin
                last = term && (p == L - 1);
                f_fwd.push_back(p < PKT_LEN);
                if (p < PKT_LEN) n_fwd_exp++;
                f_good.push_back(last && (L == PKT_LEN));
                f_short.push_back(last && (L < PKT_LEN));
                f_long.push_back((p == PKT_LEN - 1) && (L > PKT_LEN));
                f_rs.push_back((L > PKT_LEN) && (p >= PKT_LEN - 1) && !last);
`ifdef DEPKT_TUSER_CHECK_EN
                f_user.push_back((p >= 1) && (p < PKT_LEN) && (in_q[i+p].u != u0));
`else
                f_user.push_back(1'b0);
`endif
            end
            i += L;
        end
    endtask

    task automatic run_stream(input int rdy_pct, input int vld_pct);
        int  k, idle, budget;
        bit  presenting, stalled_prev;
        logic pend_short, pend_long, pend_user, pend_rs;
        logic [DATA_W+USER_W-1:0] prev_m, exp_m, got_m;
        build_model();
        exp_out.delete(); out_log.delete();
        k = 0; idle = 0; budget = in_q.size() * 10 + 100;
        presenting = 0; stalled_prev = 0;
        pend_short = 0; pend_long = 0; pend_user = 0; pend_rs = 0;
        prev_m = '0;
        n_short = 0; n_long = 0; n_user = 0; rs_cycles = 0; run_cycles = 0; src_stalls = 0;
        while (idle < 3) begin
            @(negedge clk);
            if (!presenting && (k < in_q.size()) && ($urandom_range(99) < vld_pct)) presenting = 1;
            s_if.tvalid = presenting;
            s_if.tdata  = presenting ? in_q[k].d : '0;
            s_if.tuser  = presenting ? in_q[k].u : '0;
            s_if.tlast  = presenting ? in_q[k].l : 1'b0;
            m_if.tready = ($urandom_range(99) < rdy_pct);
            #4;
            run_cycles++;
            checks++;
            if (err_short !== pend_short) begin
                errors++; $display("FAIL err_short: got %b expected %b (cycle %0d)", err_short, pend_short, run_cycles);
            end
            checks++;
            if (err_long !== pend_long) begin
                errors++; $display("FAIL err_long: got %b expected %b (cycle %0d)", err_long, pend_long, run_cycles);
            end
            checks++;
            if (resyncing !== pend_rs) begin
                errors++; $display("FAIL resyncing: got %b expected %b (cycle %0d)", resyncing, pend_rs, run_cycles);
            end
            checks++;
            if (err_count !== CNT_W'(exp_err)) begin
                errors++; $display("FAIL err_count: got %0d expected %0d", err_count, exp_err);
            end
            checks++;
            if (pkt_count !== CNT_W'(exp_pkt)) begin
                errors++; $display("FAIL pkt_count: got %0d expected %0d", pkt_count, exp_pkt);
            end
            checks++;
            if (m_if.tlast !== 1'b0) begin
                errors++; $display("FAIL m_tlast: got %b expected 0", m_if.tlast);
            end
`ifdef DEPKT_TUSER_CHECK_EN
            checks++;
            if (err_user !== pend_user) begin
                errors++; $display("FAIL err_user: got %b expected %b (cycle %0d)", err_user, pend_user, run_cycles);
            end
            if (err_user === 1'b1) n_user++;
`endif
            if (resyncing === 1'b1) rs_cycles++;
            if (err_short === 1'b1) n_short++;
            if (err_long === 1'b1) n_long++;
            got_m = {m_if.tdata, m_if.tuser};
            if (stalled_prev) begin
                checks++;
                if (m_if.tvalid !== 1'b1 || got_m !== prev_m) begin
                    errors++; $display("FAIL stall_hold: got v=%b %h expected v=1 %h", m_if.tvalid, got_m, prev_m);
                end
            end
            if (m_if.tvalid === 1'b1 && m_if.tready) begin
                checks++;
                if (exp_out.size() == 0) begin
                    errors++; $display("FAIL out_extra: got %h expected no beat", got_m);
                end else begin
                    exp_m = exp_out.pop_front();
                    if (got_m !== exp_m) begin
                        errors++; $display("FAIL out_beat: got %h expected %h", got_m, exp_m);
                    end
                end
                out_log.push_back(m_if.tdata);
            end
            stalled_prev = (m_if.tvalid === 1'b1) && !m_if.tready;
            prev_m = got_m;
            pend_short = 0; pend_long = 0; pend_user = 0;
            if (presenting && s_if.tready === 1'b1) begin
                pend_short = f_short[k];
                pend_long  = f_long[k];
                pend_user  = f_user[k];
                pend_rs    = f_rs[k];
                exp_err += longint'(f_short[k]) + longint'(f_long[k]) + longint'(f_user[k]);
                exp_pkt += longint'(f_good[k]);
                if (f_fwd[k]) exp_out.push_back({in_q[k].d, in_q[k].u});
                k++;
                presenting = 0;
            end else if (presenting) begin
                src_stalls++;
            end
            if (k == in_q.size() && exp_out.size() == 0 && !presenting) idle++;
            if (run_cycles > budget) begin
                checks++; errors++;
                $display("FAIL timeout: got %0d cycles expected <= %0d (k=%0d pending=%0d)", run_cycles, budget, k, exp_out.size());
                break;
            end
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic test_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b0;
        repeat (cycles) @(negedge clk);
        checks++;
        if ({m_if.tvalid, m_if.tlast, s_if.tready, err_short, err_long, resyncing} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                {m_if.tvalid, m_if.tlast, s_if.tready, err_short, err_long, resyncing});
        end
        checks++;
        if ({m_if.tdata, m_if.tuser} !== '0) begin
            errors++; $display("FAIL reset_mdata: got %h expected 0", {m_if.tdata, m_if.tuser});
        end
        checks++;
        if (pkt_count !== '0) begin
            errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count);
        end
        checks++;
        if (err_count !== '0) begin
            errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
`ifdef DEPKT_TUSER_CHECK_EN
        checks++;
        if (err_user !== 1'b0) begin
            errors++; $display("FAIL reset_err_user: got %b expected 0", err_user);
        end
`endif
        rst = 1'b0;
        exp_pkt = 0;
        exp_err = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_good_stream();
        int bad;
        in_q.delete();
        next_data = 1;
        add_seg(256, 8'hA5, 1);
        add_seg(256, 8'hA5, 1);
        add_seg(88, 8'hA5, 0);
        run_stream(100, 100);
        checks++;
        if (pkt_count !== 2 || err_count !== 0) begin
            errors++; $display("FAIL good_counts: got pkt=%0d err=%0d expected pkt=2 err=0", pkt_count, err_count);
        end
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            if (i >= out_log.size() || out_log[i] !== DATA_W'(i + 1)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL good_seq: got %0d wrong of first 512 expected 0", bad);
        end
        checks++;
        if (src_stalls != 0 || run_cycles > 606) begin
            errors++; $display("FAIL throughput: got stalls=%0d cycles=%0d expected 0 and <=606", src_stalls, run_cycles);
        end
    endtask

    task automatic test_short();
        in_q.delete();
        next_data = 32'h1000;
        add_seg(256, 8'h11, 1);
        add_seg(100, 8'h22, 1);
        add_seg(256, 8'h33, 1);
        run_stream(100, 100);
        checks++;
        if (n_short != 1 || err_count !== 1 || pkt_count !== 2) begin
            errors++; $display("FAIL short: got pulses=%0d err=%0d pkt=%0d expected 1 1 2", n_short, err_count, pkt_count);
        end
        checks++;
        if (out_log.size() != 612) begin
            errors++; $display("FAIL short_fwd: got %0d beats expected 612", out_log.size());
        end
    endtask

    task automatic test_long();
        in_q.delete();
        next_data = 32'h2000;
        add_seg(301, 8'h44, 1);
        add_seg(256, 8'h55, 1);
        run_stream(100, 100);
        checks++;
        if (n_long != 1 || err_count !== 1 || pkt_count !== 1) begin
            errors++; $display("FAIL long: got pulses=%0d err=%0d pkt=%0d expected 1 1 1", n_long, err_count, pkt_count);
        end
        checks++;
        if (rs_cycles != 45) begin
            errors++; $display("FAIL resync_len: got %0d cycles expected 45", rs_cycles);
        end
        checks++;
        if (out_log.size() != 512) begin
            errors++; $display("FAIL long_fwd: got %0d beats expected 512", out_log.size());
        end
    endtask

    task automatic test_random();
        int total, len;
        in_q.delete();
        next_data = $urandom;
        total = 0;
        while (total < 1000) begin
            case ($urandom_range(0, 3))
                1:       len = $urandom_range(1, PKT_LEN - 1);
                2:       len = $urandom_range(PKT_LEN + 1, PKT_LEN + 60);
                default: len = PKT_LEN;
            endcase
            add_seg(len, USER_W'($urandom), 1);
            total += len;
        end
        run_stream(50, 80);
        checks++;
        if (out_log.size() != n_fwd_exp) begin
            errors++; $display("FAIL random_fwd: got %0d beats expected %0d", out_log.size(), n_fwd_exp);
        end
    endtask

    task automatic test_mid_reset();
        in_q.delete();
        next_data = 32'h3000;
        add_seg(120, 8'h66, 0);
        run_stream(100, 100);
        // Hold beat 120 with the output blocked so the slice holds data at reset.
        @(negedge clk);
        s_if.tvalid = 1'b1;
        s_if.tdata  = next_data;
        s_if.tuser  = 8'h66;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset(1);
        in_q.delete();
        next_data = 32'h4000;
        add_seg(256, 8'h77, 1);
        run_stream(100, 100);
        checks++;
        if (pkt_count !== 1 || err_count !== 0 || n_short != 0 || n_long != 0) begin
            errors++; $display("FAIL mid_reset: got pkt=%0d err=%0d short=%0d long=%0d expected 1 0 0 0",
                pkt_count, err_count, n_short, n_long);
        end
    endtask

`ifdef DEPKT_TUSER_CHECK_EN
    task automatic test_user();
        beat_t b;
        in_q.delete();
        next_data = 32'h5000;
        add_seg(256, 8'hA5, 1);
        b = in_q[10];
        b.u = 8'h5A;
        in_q[10] = b;
        run_stream(100, 100);
        checks++;
        if (n_user != 1 || err_count !== 1 || pkt_count !== 1) begin
            errors++; $display("FAIL user: got pulses=%0d err=%0d pkt=%0d expected 1 1 1", n_user, err_count, pkt_count);
        end
    endtask
`endif

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tuser  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        next_data   = 1;
        exp_pkt     = 0;
        exp_err     = 0;
        test_reset(3);
        test_good_stream();
        test_reset(1);
        test_short();
        test_reset(1);
        test_long();
        test_reset(1);
        test_random();
        test_reset(1);
        test_mid_reset();
`ifdef DEPKT_TUSER_CHECK_EN
        test_reset(1);
        test_user();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
